uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter between N byte sources (counter stream, fault/status reporters).

---
 rtl/uart_tx_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one UART TX core between N_REQ byte sources.
//   Each granted byte goes out as a 3-byte frame: header {4'hA,id}, data, checksum (header^data).
//   A per-byte timeout aborts the frame if the TX core never reports completion.
// Ports
//   i_Clk, i_Rst          clock, synchronous active-high reset
//   i_Req[N_REQ]          per-source request, held until granted
//   i_Data[8*N_REQ]       source k byte at [8k+7:8k]
//   o_Grant[N_REQ]        one-hot 1-cycle pulse, source byte captured
//   i_Tx_Active           TX core busy
//   i_Tx_Done             TX core 1-cycle pulse, byte finished
//   o_Tx_DV, o_Tx_Byte    1-cycle start pulse and byte to the TX core
//   o_Busy                frame in progress
//   o_Err                 1-cycle pulse, timeout abort
//   o_Frames              completed frame count, wraps
module uart_tx_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic [N_REQ-1:0]     i_Req,
  input  logic [8*N_REQ-1:0]   i_Data,
  output logic [N_REQ-1:0]     o_Grant,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  output logic                 o_Busy,
  output logic                 o_Err,
  output logic [7:0]           o_Frames
);

  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_HDR = 2'd1,
    WAIT_DAT = 2'd2,
    WAIT_CHK = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_pend;
  logic [ID_W-1:0]     r_id;
  logic [7:0]          r_data;
  logic [ID_W-1:0]     r_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic [N_REQ-1:0]    r_grant;
  logic                r_dv;
  logic [7:0]          r_byte;
  logic                r_busy;
  logic                r_err;
  logic [7:0]          r_frames;

  state_t              w_state_n;
  logic                w_pend_n;
  logic [ID_W-1:0]     w_id_n;
  logic [7:0]          w_data_n;
  logic [ID_W-1:0]     w_ptr_n;
  logic [CNT_W-1:0]    w_cnt_n;
  logic [N_REQ-1:0]    w_grant_n;
  logic                w_dv_n;
  logic [7:0]          w_byte_n;
  logic                w_err_n;
  logic [7:0]          w_frames_n;

  logic [7:0]          w_hdr;
  logic                w_found;
  logic [ID_W-1:0]     w_pick;
  logic [ID_W-1:0]     w_idx;
  logic [7:0]          w_sel;

  assign w_hdr = {4'hA, 4'(r_id)};

  // First requester at or after the rr pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_idx = ID_W'((32'(r_ptr) + i) % N_REQ);
      if (!w_found && i_Req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Data byte of the picked source
  always_comb begin
    w_sel = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_pick == ID_W'(k)) w_sel = i_Data[8*k +: 8];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_n  = r_state;
    w_pend_n   = r_pend;
    w_id_n     = r_id;
    w_data_n   = r_data;
    w_ptr_n    = r_ptr;
    w_cnt_n    = r_cnt;
    w_grant_n  = '0;
    w_dv_n     = 1'b0;
    w_byte_n   = r_byte;
    w_err_n    = 1'b0;
    w_frames_n = r_frames;

    case (r_state)
      IDLE: begin
        // r_pend marks the grant cycle: header goes out on the following edge
        if (r_pend) begin
          w_pend_n  = 1'b0;
          w_dv_n    = 1'b1;
          w_byte_n  = w_hdr;
          w_cnt_n   = '0;
          w_state_n = WAIT_HDR;
          w_ptr_n   = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + 1'b1;
        end else if (w_found && !i_Tx_Active) begin
          w_grant_n[w_pick] = 1'b1;
          w_id_n            = w_pick;
          w_data_n          = w_sel;
          w_pend_n          = 1'b1;
        end
      end
      default: begin
        if (i_Tx_Done) begin
          w_cnt_n = '0;
          case (r_state)
            WAIT_HDR: begin
              w_dv_n    = 1'b1;
              w_byte_n  = r_data;
              w_state_n = WAIT_DAT;
            end
            WAIT_DAT: begin
              w_dv_n    = 1'b1;
              w_byte_n  = w_hdr ^ r_data;
              w_state_n = WAIT_CHK;
            end
            default: begin
              w_frames_n = r_frames + 8'd1;
              w_state_n  = IDLE;
            end
          endcase
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          // Done on the same edge takes priority (handled above)
          w_err_n   = 1'b1;
          w_state_n = IDLE;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state  <= IDLE;
      r_pend   <= 1'b0;
      r_id     <= '0;
      r_data   <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_grant  <= '0;
      r_dv     <= 1'b0;
      r_byte   <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_frames <= '0;
    end else begin
      r_state  <= w_state_n;
      r_pend   <= w_pend_n;
      r_id     <= w_id_n;
      r_data   <= w_data_n;
      r_ptr    <= w_ptr_n;
      r_cnt    <= w_cnt_n;
      r_grant  <= w_grant_n;
      r_dv     <= w_dv_n;
      r_byte   <= w_byte_n;
      r_busy   <= (w_state_n != IDLE);
      r_err    <= w_err_n;
      r_frames <= w_frames_n;
    end
  end

  assign o_Grant   = r_grant;
  assign o_Tx_DV   = r_dv;
  assign o_Tx_Byte = r_byte;
  assign o_Busy    = r_busy;
  assign o_Err     = r_err;
  assign o_Frames  = r_frames;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: emulated TX core, request sources and a frame-level reference model.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned DW = 8 * N;

  logic          i_Clk;
  logic          i_Rst;
  logic [N-1:0]  i_Req;
  logic [DW-1:0] i_Data;
  logic [N-1:0]  o_Grant;
  logic          i_Tx_Active;
  logic          i_Tx_Done;
  logic          o_Tx_DV;
  logic [7:0]    o_Tx_Byte;
  logic          o_Busy;
  logic          o_Err;
  logic [7:0]    o_Frames;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Req(i_Req), .i_Data(i_Data), .o_Grant(o_Grant),
    .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done), .o_Tx_DV(o_Tx_DV),
    .o_Tx_Byte(o_Tx_Byte), .o_Busy(o_Busy), .o_Err(o_Err), .o_Frames(o_Frames)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  int         n_checks = 0;
  int         n_errors = 0;

  // Reference model and emulator state
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         grant_log[$];
  int         m_ptr, cd, emu_n, fixed_d, t_since, err_seen, grants_seen, total_fr;
  logic [7:0] m_frames;
  logic       m_free, m_rel, fr_chk, dv_due, hang, hang_dv, in_rst, src_auto, saw_wrap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (((r >> ((p + i) % N)) & N'(1)) != 0) return (p + i) % N;
    return -1;
  endfunction

  task automatic set_src(input int k, input logic [7:0] b);
    i_Data = (i_Data & ~(DW'(8'hFF) << (8 * k))) | (DW'(b) << (8 * k));
  endtask

  // One clock: check outputs against the model, then emulate TX core and sources
  task automatic tick();
    logic         exp_dv, exp_err;
    logic [N-1:0] exp_g;
    int           gk;
    logic [7:0]   hdr, d;
    @(negedge i_Clk);
    exp_dv = dv_due;
    dv_due = 1'b0;
    if (o_Tx_DV) t_since = 0;
    else if (t_since < 100000) t_since++;
    if (!in_rst) begin
      exp_err = hang_dv && (t_since == int'(TO));
      exp_g = '0;
      gk = -1;
      if (m_free && (i_Req != '0) && !i_Tx_Active) begin
        gk = pick(i_Req, m_ptr);
        exp_g = N'(1) << gk;
      end
      chk("grant", 32'(o_Grant), 32'(exp_g));
      if (o_Grant != '0) grants_seen++;
      if (gk >= 0) begin
        hdr = 8'hA0 | 8'(gk);
        d = 8'(i_Data >> (8 * gk));
        exp_q.push_back(hdr);
        exp_q.push_back(d);
        exp_q.push_back(hdr ^ d);
        grant_log.push_back(gk);
        m_ptr = (gk + 1) % N;
        i_Req = i_Req & ~(N'(1) << gk);
        m_free = 1'b0;
        dv_due = 1'b1;
        chk("grant_busy", 32'(o_Busy), 32'd0);
      end
      chk("dv", 32'(o_Tx_DV), 32'(exp_dv));
      if (o_Tx_DV) begin
        chk("dv_busy", 32'(o_Busy), 32'd1);
        chk("dv_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("tx_byte", 32'(o_Tx_Byte), 32'(exp_q.pop_front()));
      end
      chk("err", 32'(o_Err), 32'(exp_err));
      if (o_Err) begin
        err_seen++;
        exp_q.delete();
        emu_n = 0;
        hang_dv = 1'b0;
        m_free = 1'b1;
        chk("err_busy", 32'(o_Busy), 32'd0);
      end
      if (fr_chk) begin
        fr_chk = 1'b0;
        chk("frames", 32'(o_Frames), 32'(m_frames));
        chk("idle_busy", 32'(o_Busy), 32'd0);
      end
    end
    // TX core emulation
    if (i_Tx_Done) i_Tx_Done = 1'b0;
    if (m_rel) begin
      m_rel = 1'b0;
      m_free = 1'b1;
    end
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        i_Tx_Done = 1'b1;
        i_Tx_Active = 1'b0;
        if (emu_n == 3) begin
          emu_n = 0;
          m_frames = m_frames + 8'd1;
          total_fr++;
          if (m_frames == 8'd0) saw_wrap = 1'b1;
          m_rel = 1'b1;
          fr_chk = 1'b1;
        end else begin
          dv_due = 1'b1;
        end
      end
    end
    if (o_Tx_DV && !in_rst) begin
      got_q.push_back(o_Tx_Byte);
      emu_n++;
      i_Tx_Active = 1'b1;
      if (hang) hang_dv = 1'b1;
      else cd = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, 12));
    end
    // Random request sources
    if (src_auto) begin
      for (int k = 0; k < N; k++) begin
        if (((i_Req >> k) & N'(1)) == '0 && $urandom_range(0, 7) == 0) begin
          set_src(k, 8'($urandom_range(0, 255)));
          i_Req = i_Req | (N'(1) << k);
        end
      end
    end
  endtask

  task automatic do_reset();
    i_Rst = 1'b1; in_rst = 1'b1;
    i_Req = '0; i_Tx_Done = 1'b0; i_Tx_Active = 1'b0;
    cd = 0; emu_n = 0; exp_q.delete(); m_ptr = 0; m_frames = 8'd0;
    m_free = 1'b0; m_rel = 1'b0; fr_chk = 1'b0; dv_due = 1'b0; hang_dv = 1'b0;
    tick();
    chk("rst_grant", 32'(o_Grant), 32'd0);
    chk("rst_dv", 32'(o_Tx_DV), 32'd0);
    chk("rst_byte", 32'(o_Tx_Byte), 32'd0);
    chk("rst_busy", 32'(o_Busy), 32'd0);
    chk("rst_err", 32'(o_Err), 32'd0);
    chk("rst_frames", 32'(o_Frames), 32'd0);
    tick();
    i_Rst = 1'b0; in_rst = 1'b0; m_free = 1'b1;
  endtask

  task automatic run_frames(input logic [7:0] target, input int bound, input string tag);
    int n = 0;
    while (m_frames != target && n < bound) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk(tag, 32'(m_frames), 32'(target));
  endtask

  initial begin
    int n;
    logic [7:0] e_b[6];
    i_Rst = 1'b1; i_Req = '0; i_Data = '0; i_Tx_Active = 1'b0; i_Tx_Done = 1'b0;
    t_since = 100000; err_seen = 0; grants_seen = 0; total_fr = 0;
    hang = 1'b0; src_auto = 1'b0; saw_wrap = 1'b0; fixed_d = 10;
    do_reset();

    // TX busy blocks grants; single frame from source 0
    set_src(0, 8'h3C);
    i_Req = 4'b0001;
    i_Tx_Active = 1'b1;
    repeat (50) tick();
    chk("active_no_grant", 32'(grants_seen), 32'd0);
    i_Tx_Active = 1'b0;
    got_q.delete();
    run_frames(8'd1, 200, "single_frame_done");
    chk("single_grants", 32'(grants_seen), 32'd1);
    e_b[0] = 8'hA0; e_b[1] = 8'h3C; e_b[2] = 8'h9C;
    chk("single_len", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) chk("single_byte", 32'(got_q[i]), 32'(e_b[i]));
    chk("single_frames", 32'(o_Frames), 32'd1);

    // Two held requests served in round-robin order
    got_q.delete(); grant_log.delete();
    set_src(1, 8'h22); set_src(3, 8'h44);
    i_Req = 4'b1010;
    run_frames(8'd3, 400, "rr_frames_done");
    e_b[0] = 8'hA1; e_b[1] = 8'h22; e_b[2] = 8'h83;
    e_b[3] = 8'hA3; e_b[4] = 8'h44; e_b[5] = 8'hE7;
    chk("rr_len", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) chk("rr_byte", 32'(got_q[i]), 32'(e_b[i]));
    chk("rr_order_n", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("rr_first", 32'(grant_log[0]), 32'd1);
      chk("rr_second", 32'(grant_log[1]), 32'd3);
    end

    // Hung TX core: timeout after header
    repeat (20) tick();
    got_q.delete();
    hang = 1'b1;
    set_src(0, 8'h5A);
    i_Req = 4'b0001;
    n = 0;
    while (err_seen == 0 && n < 100) begin tick(); n++; end
    chk("to_err_seen", 32'(err_seen), 32'd1);
    tick();
    chk("to_busy", 32'(o_Busy), 32'd0);
    chk("to_frames", 32'(o_Frames), 32'd3);
    chk("to_bytes", 32'(got_q.size()), 32'd1);
    hang = 1'b0;
    i_Tx_Active = 1'b0;
    repeat (3) tick();

    // Reset in the middle of a frame; pointer kept its advanced value (1)
    got_q.delete(); grant_log.delete();
    set_src(0, 8'h11); set_src(2, 8'h77);
    i_Req = 4'b0101;
    n = 0;
    while (got_q.size() < 2 && n < 100) begin tick(); n++; end
    chk("mid_bytes", 32'(got_q.size()), 32'd2);
    if (grant_log.size() > 0) chk("mid_grant_src", 32'(grant_log[0]), 32'd2);
    do_reset();
    got_q.delete();
    i_Tx_Done = 1'b1;
    repeat (5) tick();
    chk("stray_done_dv", 32'(got_q.size()), 32'd0);
    chk("stray_done_busy", 32'(o_Busy), 32'd0);
    chk("stray_done_frames", 32'(o_Frames), 32'd0);

    // Random traffic through the frame counter wrap
    fixed_d = 0;
    src_auto = 1'b1;
    n = 0;
    while (!(saw_wrap && total_fr >= 263) && n < 30000) begin tick(); n++; end
    src_auto = 1'b0;
    chk("rand_wrap_seen", 32'(saw_wrap), 32'd1);
    chk("rand_total", 32'(total_fr >= 263), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
